// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the two-requester RAM arbiter.
package mem_arb_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int ADDR_W_DEF  = 9;
  localparam int RAM_SEL_BIT = ADDR_W_DEF - 1;

  typedef enum logic {
    REQ_R0 = 1'b0,
    REQ_R1 = 1'b1
  } req_id_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RESP_R0 = 3'd1,
    RESP_R1 = 3'd2,
    ERR_R0  = 3'd3,
    ERR_R1  = 3'd4
  } resp_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Per-requester bus between a RAM client and the arbiter.
interface mem_req_if
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();
  // req is held with we/addr/wdata stable until gnt; req&gnt is the transfer.
  // rvalid/err are single-cycle responses one cycle after the transfer.
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin core: grants a lone requester, otherwise the priority owner.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    prio,
  output logic [1:0] gnt,
  output req_id_t    next_prio
);
  always_comb begin
    gnt       = 2'b00;
    next_prio = prio;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (prio == REQ_R0) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    if (gnt[0])      next_prio = REQ_R1;
    else if (gnt[1]) next_prio = REQ_R0;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one registered-read RAM between instruction fetch (r0) and load/store (r1);
// the top address bit selects RAM (0) or off-RAM (1), the latter answered with an error pulse.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  mem_req_if.slave          r0,
  mem_req_if.slave          r1,
  output logic [ADDR_W-2:0] ram_read_address,
  output logic [ADDR_W-2:0] ram_write_address,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output resp_state_t       dbg_state
);
  req_id_t           prio_q, prio_d, next_prio;
  resp_state_t       state_q, state_d;
  logic [ADDR_W-2:0] rd_addr_q, rd_addr_d;
  logic [1:0]        core_gnt, gnt;
  logic              any_gnt, win_sel, win_we, off_ram, rd_fire;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              r0_valid, r1_valid;

  rr_arbiter2 u_rr (
    .req       ({r1.req, r0.req}),
    .prio      (prio_q),
    .gnt       (core_gnt),
    .next_prio (next_prio)
  );

  assign gnt       = core_gnt & {2{~reset}};
  assign any_gnt   = |gnt;
  assign win_sel   = gnt[1];
  assign win_we    = win_sel ? r1.we    : r0.we;
  assign win_addr  = win_sel ? r1.addr  : r0.addr;
  assign win_wdata = win_sel ? r1.wdata : r0.wdata;
  assign off_ram   = win_addr[ADDR_W-1];
  assign rd_fire   = any_gnt & ~win_we & ~off_ram;

  // The read port keeps its last address so idle/write cycles cause no new read.
  always_comb begin
    rd_addr_d = rd_addr_q;
    prio_d    = next_prio;
    state_d   = IDLE;
    if (rd_fire) rd_addr_d = win_addr[ADDR_W-2:0];
    if (any_gnt) begin
      if (off_ram)     state_d = win_sel ? ERR_R1  : ERR_R0;
      else if (!win_we) state_d = win_sel ? RESP_R1 : RESP_R0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q    <= REQ_R0;
      state_q   <= IDLE;
      rd_addr_q <= '0;
    end else begin
      prio_q    <= prio_d;
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  assign ram_read_address  = rd_addr_d;
  assign ram_write_address = win_addr[ADDR_W-2:0];
  assign ram_din           = win_wdata;
  assign ram_write         = any_gnt & win_we & ~off_ram;

  // Responses are masked while reset is high so an in-flight read is dropped.
  assign r0_valid  = (state_q == RESP_R0) & ~reset;
  assign r1_valid  = (state_q == RESP_R1) & ~reset;
  assign r0.gnt    = gnt[0];
  assign r1.gnt    = gnt[1];
  assign r0.rvalid = r0_valid;
  assign r1.rvalid = r1_valid;
  assign r0.rdata  = r0_valid ? ram_dout : '0;
  assign r1.rdata  = r1_valid ? ram_dout : '0;
  assign r0.err    = (state_q == ERR_R0) & ~reset;
  assign r1.err    = (state_q == ERR_R1) & ~reset;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural registered-read RAM.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  ram_read_address, ram_write_address;
  logic        ram_write;
  logic [15:0] ram_din, ram_dout;
  resp_state_t dbg_state;
  int          tests_run = 0;
  int          tests_failed = 0;

  always #5 clk = ~clk;

  mem_req_if r0_if ();
  mem_req_if r1_if ();

  mem_arbiter #(.DATA_W(16), .ADDR_W(9)) dut (
    .clk               (clk),
    .reset             (reset),
    .r0                (r0_if),
    .r1                (r1_if),
    .ram_read_address  (ram_read_address),
    .ram_write_address (ram_write_address),
    .ram_write         (ram_write),
    .ram_din           (ram_din),
    .ram_dout          (ram_dout),
    .dbg_state         (dbg_state)
  );

  logic [15:0] mem [0:255];
  always @(posedge clk) begin
    if (ram_write) mem[ram_write_address] <= ram_din;
    ram_dout <= mem[ram_read_address];
  end

  task automatic set_r0(input logic req, input logic we, input logic [8:0] addr, input logic [15:0] wdata);
    r0_if.req = req; r0_if.we = we; r0_if.addr = addr; r0_if.wdata = wdata;
  endtask

  task automatic set_r1(input logic req, input logic we, input logic [8:0] addr, input logic [15:0] wdata);
    r1_if.req = req; r1_if.we = we; r1_if.addr = addr; r1_if.wdata = wdata;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_r0(1, 0, 9'h000, 0);
    set_r1(1, 0, 9'h001, 0);
    @(negedge clk); #1;
    tests_run++;
    if ({r1_if.gnt, r0_if.gnt} !== 2'b00) begin
      tests_failed++; $display("FAIL reset_gnt: got %b expected 00", {r1_if.gnt, r0_if.gnt});
    end
    @(negedge clk);
    reset = 1'b0;
    set_r0(0, 0, 0, 0); set_r1(0, 0, 0, 0);
    #1;
    tests_run++;
    if ({r1_if.rvalid, r0_if.rvalid, r1_if.err, r0_if.err, ram_write} !== 5'b0 || dbg_state !== IDLE) begin
      tests_failed++;
      $display("FAIL reset_state: got rv=%b err=%b we=%b st=%0d expected all 0, IDLE",
               {r1_if.rvalid, r0_if.rvalid}, {r1_if.err, r0_if.err}, ram_write, dbg_state);
    end
  endtask

  task automatic test_write_read();
    @(negedge clk); set_r1(1, 1, 9'h005, 16'hBEEF); #1;
    tests_run++;
    if ({r1_if.gnt, r0_if.gnt, ram_write} !== 3'b101 || ram_write_address !== 8'h05 || ram_din !== 16'hBEEF) begin
      tests_failed++;
      $display("FAIL wr_cycle: got gnt=%b we=%b wa=%h din=%h expected 10 1 05 beef",
               {r1_if.gnt, r0_if.gnt}, ram_write, ram_write_address, ram_din);
    end
    @(negedge clk); set_r1(1, 0, 9'h005, 0); #1;
    tests_run++;
    if ({r1_if.gnt, ram_write, r1_if.rvalid} !== 3'b100 || ram_read_address !== 8'h05) begin
      tests_failed++;
      $display("FAIL rd_cycle: got gnt=%b we=%b rv=%b ra=%h expected 1 0 0 05",
               r1_if.gnt, ram_write, r1_if.rvalid, ram_read_address);
    end
    @(negedge clk); set_r1(0, 0, 0, 0); #1;
    tests_run++;
    if (r1_if.rvalid !== 1'b1 || r1_if.rdata !== 16'hBEEF || r0_if.rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL raw_data: got rv=%b rdata=%h r0rv=%b expected 1 beef 0",
               r1_if.rvalid, r1_if.rdata, r0_if.rvalid);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); set_r1(1, 1, 9'(i), 16'(16'h1111 * (i + 1))); #1;
      tests_run++;
      if (r1_if.gnt !== 1'b1 || ram_write !== 1'b1) begin
        tests_failed++; $display("FAIL preload_%0d: got gnt=%b we=%b expected 1 1", i, r1_if.gnt, ram_write);
      end
    end
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i < 4) set_r1(1, 0, 9'(i), 0);
      else       set_r1(0, 0, 0, 0);
      #1;
      tests_run++;
      if (r1_if.gnt !== (i < 4)) begin
        tests_failed++; $display("FAIL b2b_gnt_%0d: got %b expected %b", i, r1_if.gnt, (i < 4));
      end
      if (i > 0) begin
        tests_run++;
        if (r1_if.rvalid !== 1'b1 || r1_if.rdata !== 16'(16'h1111 * i)) begin
          tests_failed++;
          $display("FAIL b2b_data_%0d: got rv=%b rdata=%h expected 1 %h", i, r1_if.rvalid, r1_if.rdata, 16'(16'h1111 * i));
        end
      end
    end
    @(negedge clk); #1;
    tests_run++;
    if (r1_if.rvalid !== 1'b0 || r1_if.rdata !== 16'h0000) begin
      tests_failed++; $display("FAIL idle_rdata: got rv=%b rdata=%h expected 0 0000", r1_if.rvalid, r1_if.rdata);
    end
  endtask

  task automatic test_alternate();
    logic [1:0]  exp_gnt, exp_rv;
    logic [15:0] exp_data, got_data;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k < 8) begin set_r0(1, 0, 9'h000, 0); set_r1(1, 0, 9'h001, 0); end
      else begin set_r0(0, 0, 0, 0); set_r1(0, 0, 0, 0); end
      #1;
      exp_gnt = (k == 8) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10);
      tests_run++;
      if ({r1_if.gnt, r0_if.gnt} !== exp_gnt) begin
        tests_failed++; $display("FAIL alt_gnt_%0d: got %b expected %b", k, {r1_if.gnt, r0_if.gnt}, exp_gnt);
      end
      if (k > 0) begin
        exp_rv   = ((k - 1) % 2 == 0) ? 2'b01 : 2'b10;
        exp_data = ((k - 1) % 2 == 0) ? 16'h1111 : 16'h2222;
        got_data = r0_if.rdata | r1_if.rdata;
        tests_run++;
        if ({r1_if.rvalid, r0_if.rvalid} !== exp_rv || got_data !== exp_data) begin
          tests_failed++;
          $display("FAIL alt_rv_%0d: got rv=%b data=%h expected %b %h", k, {r1_if.rvalid, r0_if.rvalid}, got_data, exp_rv, exp_data);
        end
      end
    end
  endtask

  task automatic test_off_ram();
    @(negedge clk); set_r0(1, 0, 9'h100, 0); #1;
    tests_run++;
    if (r0_if.gnt !== 1'b1 || ram_write !== 1'b0 || ram_read_address !== 8'h01) begin
      tests_failed++;
      $display("FAIL io_rd_gnt: got gnt=%b we=%b ra=%h expected 1 0 01", r0_if.gnt, ram_write, ram_read_address);
    end
    @(negedge clk); set_r0(1, 1, 9'h1AB, 16'hDEAD); #1;
    tests_run++;
    if (r0_if.err !== 1'b1 || r0_if.rvalid !== 1'b0 || r0_if.rdata !== 16'h0000) begin
      tests_failed++;
      $display("FAIL io_rd_err: got err=%b rv=%b rdata=%h expected 1 0 0000", r0_if.err, r0_if.rvalid, r0_if.rdata);
    end
    tests_run++;
    if (r0_if.gnt !== 1'b1 || ram_write !== 1'b0) begin
      tests_failed++; $display("FAIL io_wr_gnt: got gnt=%b we=%b expected 1 0", r0_if.gnt, ram_write);
    end
    @(negedge clk); set_r0(0, 0, 0, 0); #1;
    tests_run++;
    if (r0_if.err !== 1'b1 || r1_if.err !== 1'b0) begin
      tests_failed++; $display("FAIL io_wr_err: got err=%b%b expected 01", r1_if.err, r0_if.err);
    end
    @(negedge clk); #1;
    tests_run++;
    if (r0_if.err !== 1'b0) begin
      tests_failed++; $display("FAIL io_err_pulse: got %b expected 0", r0_if.err);
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk); set_r0(1, 0, 9'h002, 0); #1;
    tests_run++;
    if (r0_if.gnt !== 1'b1) begin
      tests_failed++; $display("FAIL mid_gnt: got %b expected 1", r0_if.gnt);
    end
    @(negedge clk); reset = 1'b1; set_r0(0, 0, 0, 0); #1;
    tests_run++;
    if (r0_if.rvalid !== 1'b0) begin
      tests_failed++; $display("FAIL mid_drop: got rv=%b expected 0", r0_if.rvalid);
    end
    @(negedge clk); reset = 1'b0;
    set_r0(1, 0, 9'h000, 0); set_r1(1, 0, 9'h001, 0); #1;
    tests_run++;
    if ({r1_if.gnt, r0_if.gnt} !== 2'b01 || {r1_if.rvalid, r0_if.rvalid} !== 2'b00) begin
      tests_failed++;
      $display("FAIL mid_prio: got gnt=%b rv=%b expected 01 00", {r1_if.gnt, r0_if.gnt}, {r1_if.rvalid, r0_if.rvalid});
    end
    @(negedge clk); set_r0(0, 0, 0, 0); set_r1(0, 0, 0, 0); #1;
    tests_run++;
    if (r0_if.rvalid !== 1'b1 || r0_if.rdata !== 16'h1111) begin
      tests_failed++; $display("FAIL mid_resume: got rv=%b rdata=%h expected 1 1111", r0_if.rvalid, r0_if.rdata);
    end
  endtask

  task automatic test_fairness();
    int wait_cycles = -1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_r1(1, 0, 9'h003, 0);
      if (wait_cycles < 0) set_r0(1, 0, 9'h002, 0);
      else                 set_r0(0, 0, 0, 0);
      #1;
      if (i == 0) begin
        tests_run++;
        if (r1_if.gnt !== 1'b1) begin
          tests_failed++; $display("FAIL fair_r1_first: got %b expected 1", r1_if.gnt);
        end
      end
      if (wait_cycles < 0 && r0_if.gnt === 1'b1) wait_cycles = i;
    end
    @(negedge clk); set_r0(0, 0, 0, 0); set_r1(0, 0, 0, 0);
    @(negedge clk);
    tests_run++;
    if (wait_cycles < 0 || wait_cycles > 1) begin
      tests_failed++; $display("FAIL fair_bound: r0 waited %0d cycles expected at most 1", wait_cycles);
    end
  endtask

  initial begin
    set_r0(0, 0, 0, 0);
    set_r1(0, 0, 0, 0);
    test_reset();
    test_write_read();
    test_back_to_back();
    test_alternate();
    test_off_ram();
    test_reset_midflight();
    test_fairness();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
